// File: rtl/pipe_stage_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_reg
//   Generic inter-stage pipeline register with valid/ready handshake, flush
//   and an optional 2-entry skid buffer. Stalls come purely from the
//   handshake (valid_I high while ready_O low); there is no enable pin.
//   ctrl_O is forced to zero whenever valid_O is low, so an empty slot is
//   seen downstream as a NOP.
//
//   state | meaning
//   ------+----------------------------------------------
//   EMPTY | nothing held, valid_O=0
//   ONE   | one entry held in main reg
//   FULL  | main reg + skid reg both held (SKID_EN=1 only)
//
// Ports
//   clk_I    in   1       clock, rising edge
//   reset_I  in   1       asynchronous, active-low reset
//   flush_I  in   1       squash all held entries
//   valid_I  in   1       upstream entry valid
//   ready_O  out  1       this stage can accept an entry
//   data_I   in   DATA_W  upstream datapath payload
//   ctrl_I   in   CTRL_W  upstream control payload
//   valid_O  out  1       output entry valid
//   ready_I  in   1       downstream accepts output entry
//   data_O   out  DATA_W  output datapath payload (main reg)
//   ctrl_O   out  CTRL_W  output control payload, zero when valid_O=0
//   occ_O    out  2       entries held (0, 1, 2)
// ---------------------------------------------------------------------------
module pipe_stage_skid_reg #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 16,
  parameter int SKID_EN  = 1,
  parameter int CLR_DATA = 0
) (
  input  logic              clk_I,
  input  logic              reset_I,
  input  logic              flush_I,
  input  logic              valid_I,
  output logic              ready_O,
  input  logic [DATA_W-1:0] data_I,
  input  logic [CTRL_W-1:0] ctrl_I,
  output logic              valid_O,
  input  logic              ready_I,
  output logic [DATA_W-1:0] data_O,
  output logic [CTRL_W-1:0] ctrl_O,
  output logic [1:0]        occ_O
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_xfer;
  logic              out_xfer;

  assign valid_O = (state != EMPTY);

  // With the skid buffer ready_O comes straight from the state flops, which
  // breaks the combinational ready path back up the pipe. Without it, a held
  // entry can be replaced in the same cycle it leaves.
  assign ready_O = (SKID_EN != 0) ? (state != FULL) : (ready_I | ~valid_O);

  assign in_xfer  = valid_I & ready_O;
  assign out_xfer = valid_O & ready_I;

  assign data_O = main_data;
  assign ctrl_O = valid_O ? main_ctrl : '0;
  // State encoding equals the entry count.
  assign occ_O  = state;

  always_ff @(posedge clk_I or negedge reset_I) begin
    if (!reset_I) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush_I) begin
      // A concurrent OUT needs no action: downstream has already taken it.
      // A concurrent IN is simply not captured.
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      if (CLR_DATA != 0) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_data <= data_I;
            main_ctrl <= ctrl_I;
            state     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_data <= data_I;
            main_ctrl <= ctrl_I;
          end else if (in_xfer) begin
            // Only reachable with SKID_EN=1; main keeps the older entry.
            skid_data <= data_I;
            skid_ctrl <= ctrl_I;
            state     <= FULL;
          end else if (out_xfer) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
